// File: rtl/eight_div_module.sv
// eight_div_module: iterative 8-bit restoring divider, one quotient bit per clock.
// Define EIGHT_DIV_REM_EN to add the registered remainder output.
module eight_div_module #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic             div_zero
`ifdef EIGHT_DIV_REM_EN
    ,
    output logic [WIDTH-1:0] remainder
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH:0] r_q, r_d, r_sh, r_sub;
    logic [WIDTH-1:0] dvd_q, dvd_d, b_q, b_d, quo_q, quo_d;
    logic [3:0] cnt_q, cnt_d;
    logic busy_q, busy_d, done_q, done_d, dz_q, dz_d, ge;
    always_comb begin
        r_sh    = {r_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        ge      = r_sh >= {1'b0, b_q};
        r_sub   = ge ? r_sh - {1'b0, b_q} : r_sh;
        state_d = state_q;
        r_d     = r_q;
        dvd_d   = dvd_q;
        b_d     = b_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                r_d     = '0;
                dvd_d   = a;
                b_d     = b;
                cnt_d   = 4'(WIDTH - 1);
                busy_d  = 1'b1;
                dz_d    = b == '0;
            end
            // dividend register doubles as the quotient shift register
            RUN: begin
                r_d    = r_sub;
                dvd_d  = {dvd_q[WIDTH-2:0], ge};
                cnt_d  = cnt_q - 4'd1;
                busy_d = cnt_q != 4'd0;
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    quo_d   = {dvd_q[WIDTH-2:0], ge};
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            dvd_q   <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            dvd_q   <= dvd_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end
    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;
    assign div_zero = dz_q;
`ifdef EIGHT_DIV_REM_EN
    logic [WIDTH-1:0] rem_q, rem_d;
    assign rem_d = done_d ? r_sub[WIDTH-1:0] : rem_q;
    always_ff @(posedge clk) begin
        if (rst) rem_q <= '0;
        else     rem_q <= rem_d;
    end
    assign remainder = rem_q;
`endif
endmodule
